cache_snoop_bcast: RTL and testbench

- Parametrised multi-core snoop broadcaster between the L2 coherence controller and NUM_CORE L1 caches.
- Accepts one upstream snoop request (CUREQ_RD / CUREQ_INV / CUREQ_RDINV) and fans it out to every core except the optional source core.
- Collects all per-core responses, merges status and dirty data, and returns a single aggregated response.
- Generalises the single-L1 cureq/cdrsp channel to N channels with independent per-core handshakes.

---
 rtl/cache_snoop_bcast_pkg.sv | 23 ++
 rtl/cache_snoop_chan.sv | 54 +++++
 rtl/cache_snoop_bcast.sv | 158 +++++++++++++++
 tb/tb_cache_snoop_bcast.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_snoop_bcast_pkg.sv
// Shared encodings for the L2-to-L1 snoop broadcaster.
// Optional response timeout is enabled with the SNOOP_TIMEOUT_EN macro.
package cache_snoop_bcast_pkg;

  localparam logic [1:0] CUREQ_RD    = 2'b00;
  localparam logic [1:0] CUREQ_INV   = 2'b01;
  localparam logic [1:0] CUREQ_RDINV = 2'b10;

  localparam logic [1:0] CDRSP_OKAY  = 2'b00;
  localparam logic [1:0] CDRSP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    SBC_IDLE  = 2'b00,
    SBC_BCAST = 2'b01,
    SBC_RSP   = 2'b10
  } sbc_state_e;

  // More than one bit set: used to flag several dirty responders in one cycle.
  function automatic logic multi_hot(input logic [15:0] v);
    return (v & (v - 16'd1)) != 16'd0;
  endfunction

endpackage

// File: rtl/cache_snoop_chan.sv
// One L1 snoop channel: request/response pending bits and per-core handshakes.
module cache_snoop_chan
  import cache_snoop_bcast_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              start_req,
  input  logic              active,
  input  logic              drop,
  output logic              cureq_valid,
  input  logic              cureq_ready,
  input  logic              cdrsp_valid,
  output logic              cdrsp_ready,
  input  logic [1:0]        cdrsp_rsp,
  input  logic              cdrsp_dirty,
  input  logic [DATA_W-1:0] cdrsp_data,
  output logic              acc_err,
  output logic              acc_dirty,
  output logic [DATA_W-1:0] acc_data,
  output logic              busy_nxt
);

  logic req_pend, rsp_pend, req_hs, acc;

  assign cureq_valid = req_pend & active;
  assign cdrsp_ready = rsp_pend & active;
  assign req_hs      = cureq_valid & cureq_ready;
  assign acc         = cdrsp_valid & cdrsp_ready;
  assign acc_err     = acc & (cdrsp_rsp == CDRSP_ERROR);
  assign acc_dirty   = acc & cdrsp_dirty;
  assign acc_data    = cdrsp_data;
  // rsp_pend is set by the request handshake, so a response this cycle is impossible.
  assign busy_nxt    = req_pend | (rsp_pend & ~acc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_pend <= 1'b0;
      rsp_pend <= 1'b0;
    end else if (start) begin
      req_pend <= start_req;
      rsp_pend <= 1'b0;
    end else if (drop) begin
      req_pend <= 1'b0;
      rsp_pend <= 1'b0;
    end else if (active) begin
      if (req_hs) req_pend <= 1'b0;
      rsp_pend <= (rsp_pend & ~acc) | req_hs;
    end
  end

endmodule

// File: rtl/cache_snoop_bcast.sv
// Fans one snoop out to all L1s except the source, merges status and dirty data.
// SNOOP_TIMEOUT_EN adds a response timeout of TIMEOUT_CYC cycles.
module cache_snoop_bcast
  import cache_snoop_bcast_pkg::*;
#(
  parameter int NUM_CORE    = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 64,
  parameter int ID_W        = (NUM_CORE > 1) ? $clog2(NUM_CORE) : 1,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sreq_valid,
  output logic                       sreq_ready,
  input  logic [1:0]                 sreq_op,
  input  logic [ADDR_W-1:0]          sreq_addr,
  input  logic                       sreq_src_vld,
  input  logic [ID_W-1:0]            sreq_src_id,
  output logic [NUM_CORE-1:0]        cureq_valid,
  input  logic [NUM_CORE-1:0]        cureq_ready,
  output logic [1:0]                 cureq_op,
  output logic [ADDR_W-1:0]          cureq_addr,
  input  logic [NUM_CORE-1:0]        cdrsp_valid,
  output logic [NUM_CORE-1:0]        cdrsp_ready,
  input  logic [2*NUM_CORE-1:0]      cdrsp_rsp,
  input  logic [NUM_CORE-1:0]        cdrsp_dirty,
  input  logic [DATA_W*NUM_CORE-1:0] cdrsp_data,
  output logic                       srsp_valid,
  input  logic                       srsp_ready,
  output logic [1:0]                 srsp_rsp,
  output logic                       srsp_dirty,
  output logic [DATA_W-1:0]          srsp_data
);

  typedef struct packed {
    logic [1:0]        op;
    logic [ADDR_W-1:0] addr;
  } sreq_t;

  typedef struct packed {
    logic              err;
    logic              dirty;
    logic [DATA_W-1:0] data;
  } srsp_t;

  sbc_state_e state, state_nxt;
  sreq_t      req_q;
  srsp_t      acc_q, acc_nxt;

  logic                             accept, in_bcast, done, timeout;
  logic [NUM_CORE-1:0]              req_mask_in, acc_err, acc_dirty, busy_nxt, dirty_vec;
  logic [NUM_CORE-1:0][DATA_W-1:0]  acc_data;
  logic [DATA_W-1:0]                sel_data;

  // Held low during reset so every output reads 0 while rst is asserted.
  assign sreq_ready = (state == SBC_IDLE) & ~rst;
  assign accept     = sreq_valid & sreq_ready;
  assign in_bcast   = (state == SBC_BCAST);
  assign done       = ~|busy_nxt;

  always_comb begin
    req_mask_in = '1;
    for (int i = 0; i < NUM_CORE; i++)
      if (sreq_src_vld && sreq_src_id == ID_W'(i)) req_mask_in[i] = 1'b0;
  end

  for (genvar i = 0; i < NUM_CORE; i++) begin : g_chan
    cache_snoop_chan #(.DATA_W(DATA_W)) u_chan (
      .clk         (clk),
      .rst         (rst),
      .start       (accept),
      .start_req   (req_mask_in[i]),
      .active      (in_bcast),
      .drop        (timeout),
      .cureq_valid (cureq_valid[i]),
      .cureq_ready (cureq_ready[i]),
      .cdrsp_valid (cdrsp_valid[i]),
      .cdrsp_ready (cdrsp_ready[i]),
      .cdrsp_rsp   (cdrsp_rsp[2*i +: 2]),
      .cdrsp_dirty (cdrsp_dirty[i]),
      .cdrsp_data  (cdrsp_data[i*DATA_W +: DATA_W]),
      .acc_err     (acc_err[i]),
      .acc_dirty   (acc_dirty[i]),
      .acc_data    (acc_data[i]),
      .busy_nxt    (busy_nxt[i])
    );
  end

`ifdef SNOOP_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] to_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           to_cnt <= '0;
    else if (accept)   to_cnt <= '0;
    else if (in_bcast) to_cnt <= to_cnt + CNT_W'(1);
  end

  // Counter starts at 0 on the first BCAST cycle; response lands TIMEOUT_CYC cycles later.
  assign timeout = in_bcast & ~done & (to_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
  assign timeout = 1'b0;
`endif

  // First dirty responder in time wins; ties go to the lowest index.
  always_comb begin
    dirty_vec = (req_q.op != CUREQ_INV) ? acc_dirty : '0;
    sel_data  = '0;
    for (int i = NUM_CORE - 1; i >= 0; i--)
      if (dirty_vec[i]) sel_data = acc_data[i];
    acc_nxt = acc_q;
    if (in_bcast) begin
      acc_nxt.err = acc_q.err | (|acc_err) | multi_hot(16'(dirty_vec))
                  | (acc_q.dirty & (|dirty_vec)) | timeout;
      if (!acc_q.dirty && (|dirty_vec)) begin
        acc_nxt.dirty = 1'b1;
        acc_nxt.data  = sel_data;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SBC_IDLE:  if (accept) state_nxt = (|req_mask_in) ? SBC_BCAST : SBC_RSP;
      SBC_BCAST: if (done || timeout) state_nxt = SBC_RSP;
      SBC_RSP:   if (srsp_ready) state_nxt = SBC_IDLE;
      default:   state_nxt = SBC_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SBC_IDLE;
      req_q <= '0;
      acc_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        req_q <= '{op: sreq_op, addr: sreq_addr};
        acc_q <= '0;
      end else begin
        acc_q <= acc_nxt;
      end
    end
  end

  assign cureq_op   = req_q.op;
  assign cureq_addr = req_q.addr;
  assign srsp_valid = (state == SBC_RSP);
  assign srsp_rsp   = (srsp_valid && acc_q.err) ? CDRSP_ERROR : CDRSP_OKAY;
  assign srsp_dirty = srsp_valid & acc_q.dirty;
  assign srsp_data  = srsp_valid ? acc_q.data : '0;

endmodule

// File: tb/tb_cache_snoop_bcast.sv
// Directed plus randomized bench for cache_snoop_bcast with behavioural L1 agents.
module tb_cache_snoop_bcast;
  import cache_snoop_bcast_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         sreq_valid, sreq_ready, sreq_src_vld;
  logic [1:0]   sreq_op, sreq_src_id;
  logic [31:0]  sreq_addr;
  logic [3:0]   cureq_valid, cureq_ready, cdrsp_valid, cdrsp_ready, cdrsp_dirty;
  logic [1:0]   cureq_op;
  logic [31:0]  cureq_addr;
  logic [7:0]   cdrsp_rsp;
  logic [255:0] cdrsp_data;
  logic         srsp_valid, srsp_ready, srsp_dirty;
  logic [1:0]   srsp_rsp;
  logic [63:0]  srsp_data;

  cache_snoop_bcast #(.NUM_CORE(4), .ADDR_W(32), .DATA_W(64), .ID_W(2), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .sreq_valid(sreq_valid), .sreq_ready(sreq_ready), .sreq_op(sreq_op), .sreq_addr(sreq_addr),
    .sreq_src_vld(sreq_src_vld), .sreq_src_id(sreq_src_id),
    .cureq_valid(cureq_valid), .cureq_ready(cureq_ready), .cureq_op(cureq_op), .cureq_addr(cureq_addr),
    .cdrsp_valid(cdrsp_valid), .cdrsp_ready(cdrsp_ready), .cdrsp_rsp(cdrsp_rsp),
    .cdrsp_dirty(cdrsp_dirty), .cdrsp_data(cdrsp_data),
    .srsp_valid(srsp_valid), .srsp_ready(srsp_ready), .srsp_rsp(srsp_rsp),
    .srsp_dirty(srsp_dirty), .srsp_data(srsp_data)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0, win = 0;

  // per-core plan for the current transaction
  logic [1:0]  p_rsp[4];
  logic        p_dirty[4];
  logic [63:0] p_data[4];
  int          p_rdy[4], p_dly[4];

  // agent state
  logic [3:0] req_done, rsp_done, seen_mask;
  logic       bad_proto;
  int         acc_win[4], rdy_cnt[4], dly_cnt[4];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1ns after each edge; handshakes are resolved at the next edge.
  task automatic step();
    logic [3:0] hr, hp;
    hr = cureq_valid & cureq_ready;
    hp = cdrsp_valid & cdrsp_ready;
    @(posedge clk); #1; win++;
    for (int i = 0; i < 4; i++) begin
      if (hr[i]) req_done[i] = 1'b1;
      if (hp[i]) begin rsp_done[i] = 1'b1; acc_win[i] = win - 1; end
    end
  endtask

  task automatic init_agent();
    for (int i = 0; i < 4; i++) begin
      acc_win[i] = 0; rdy_cnt[i] = p_rdy[i]; dly_cnt[i] = p_dly[i];
    end
    req_done = '0; rsp_done = '0; seen_mask = '0; bad_proto = 1'b0;
    cureq_ready = '0; cdrsp_valid = '0; srsp_ready = 1'b0;
  endtask

  task automatic drive_cores();
    for (int i = 0; i < 4; i++) begin
      if (cureq_valid[i]) seen_mask[i] = 1'b1;
      if (cureq_valid[i] && req_done[i]) bad_proto = 1'b1;
      if (cdrsp_ready[i] && (!req_done[i] || rsp_done[i])) bad_proto = 1'b1;
      cureq_ready[i] = (rdy_cnt[i] == 0);
      if (cureq_valid[i] && rdy_cnt[i] > 0) rdy_cnt[i]--;
      cdrsp_valid[i] = 1'b0;
      if (req_done[i] && !rsp_done[i]) begin
        if (dly_cnt[i] == 0) begin
          cdrsp_valid[i]         = 1'b1;
          cdrsp_rsp[2*i +: 2]    = p_rsp[i];
          cdrsp_dirty[i]         = p_dirty[i];
          cdrsp_data[64*i +: 64] = p_data[i];
        end else dly_cnt[i]--;
      end
    end
  endtask

  task automatic set_clean();
    for (int i = 0; i < 4; i++) begin
      p_rsp[i] = CDRSP_OKAY; p_dirty[i] = 1'b0; p_data[i] = '0; p_rdy[i] = 0; p_dly[i] = 0;
    end
  endtask

  task automatic run_txn(input logic [1:0] op, input logic [31:0] addr, input logic sv,
                         input logic [1:0] sid, input int hold, input int exp_lat,
                         input logic to_mode, input string tag);
    logic [3:0]  exp_mask;
    logic        bad_bus, e_err, e_dirty;
    logic [63:0] e_data;
    logic [67:0] e_bundle;
    int          n, acc_w, rsp_w, nd, first;
    init_agent();
    bad_bus = 1'b0;
    sreq_valid = 1'b1; sreq_op = op; sreq_addr = addr; sreq_src_vld = sv; sreq_src_id = sid;
    n = 0;
    while (!sreq_ready && n < 50) begin step(); n++; end
    chk({tag, "_sreq_ready"}, 128'(sreq_ready), 128'(1));
    acc_w = win;
    step();
    sreq_valid = 1'b0; sreq_op = 2'($urandom); sreq_addr = $urandom;
    n = 0;
    while (!srsp_valid && n < 400) begin
      if (cureq_op !== op || cureq_addr !== addr) bad_bus = 1'b1;
      drive_cores();
      step();
      n++;
    end
    cdrsp_valid = '0; cureq_ready = '0;
    rsp_w = win;
    chk({tag, "_srsp_seen"}, 128'(srsp_valid), 128'(1));
    if (exp_lat >= 0) chk({tag, "_latency"}, 128'(rsp_w - acc_w), 128'(exp_lat));

    // reference: excluded source, error OR, single dirty owner, first-in-time dirty data
    exp_mask = sv ? ~(4'b0001 << sid) : 4'hf;
    e_err = to_mode; nd = 0; first = -1;
    for (int i = 0; i < 4; i++) begin
      if (exp_mask[i] && (!to_mode || rsp_done[i])) begin
        if (p_rsp[i] == CDRSP_ERROR) e_err = 1'b1;
        if (op != CUREQ_INV && p_dirty[i]) begin
          nd++;
          if (first < 0 || acc_win[i] < acc_win[first]) first = i;
        end
      end
    end
    if (nd > 1) e_err = 1'b1;
    e_dirty  = (nd > 0);
    e_data   = (nd > 0) ? p_data[first] : 64'd0;
    e_bundle = {1'b1, e_err ? CDRSP_ERROR : CDRSP_OKAY, e_dirty, e_data};

    chk({tag, "_mask"}, 128'(seen_mask), 128'(exp_mask));
    chk({tag, "_proto"}, 128'(bad_proto), 128'(0));
    chk({tag, "_bus"}, 128'(bad_bus), 128'(0));
    chk({tag, "_srsp"}, 128'({srsp_valid, srsp_rsp, srsp_dirty, srsp_data}), 128'(e_bundle));
    for (int k = 0; k < hold; k++) begin
      step();
      chk({tag, "_hold"}, 128'({srsp_valid, srsp_rsp, srsp_dirty, srsp_data}), 128'(e_bundle));
    end
    srsp_ready = 1'b1;
    step();
    srsp_ready = 1'b0;
    chk({tag, "_done"}, 128'({srsp_valid, sreq_ready}), 128'(2'b01));
  endtask

  initial begin
    rst = 1'b1;
    sreq_valid = 1'b0; sreq_op = '0; sreq_addr = '0; sreq_src_vld = 1'b0; sreq_src_id = '0;
    cureq_ready = '0; cdrsp_valid = '0; cdrsp_rsp = '0; cdrsp_dirty = '0; cdrsp_data = '0;
    srsp_ready = 1'b0;
    set_clean();
    init_agent();
    step(); step();
    chk("reset_outputs", 128'({sreq_ready, cureq_valid, cdrsp_ready, srsp_valid, srsp_rsp,
                               srsp_dirty, cureq_op, cureq_addr, srsp_data}), 128'(0));
    rst = 1'b0;
    step();
    chk("reset_release", 128'(sreq_ready), 128'(1));

    // RD excluding core 2, minimum latency
    set_clean();
    run_txn(CUREQ_RD, 32'h1000, 1'b1, 2'd2, 0, 3, 1'b0, "rd_src2");

    // RDINV with a single dirty owner
    set_clean();
    p_dirty[1] = 1'b1; p_data[1] = 64'hDEADBEEF_CAFEF00D;
    run_txn(CUREQ_RDINV, 32'h2040, 1'b0, 2'd0, 1, -1, 1'b0, "rdinv_dirty");

    // staggered ready (core0 at cycle 1, core3 at cycle 7), out-of-order responses
    set_clean();
    p_rdy[0] = 0; p_rdy[1] = 2; p_rdy[2] = 4; p_rdy[3] = 6;
    p_dly[0] = 5; p_dly[1] = 0; p_dly[2] = 3; p_dly[3] = 0;
    p_dirty[2] = 1'b1; p_data[2] = 64'h0123_4567_89AB_CDEF;
    run_txn(CUREQ_RD, 32'h0000_3F80, 1'b0, 2'd0, 0, -1, 1'b0, "stagger");

    // two dirty responders in the same cycle
    set_clean();
    p_dirty[0] = 1'b1; p_data[0] = 64'h1111_0000_0000_1111;
    p_dirty[3] = 1'b1; p_data[3] = 64'h3333_0000_0000_3333;
    run_txn(CUREQ_RD, 32'h5000, 1'b0, 2'd0, 0, 3, 1'b0, "dual_dirty");

    // INV: dirty ignored, error propagates, response held under back-pressure
    set_clean();
    p_dirty[2] = 1'b1; p_rsp[2] = CDRSP_ERROR; p_data[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    run_txn(CUREQ_INV, 32'h6000, 1'b1, 2'd0, 5, -1, 1'b0, "inv_err");

    // reset in the middle of a broadcast
    set_clean();
    for (int i = 0; i < 4; i++) p_rdy[i] = 1000;
    init_agent();
    sreq_valid = 1'b1; sreq_op = CUREQ_RD; sreq_addr = 32'h7000; sreq_src_vld = 1'b0;
    chk("rst_mid_ready", 128'(sreq_ready), 128'(1));
    step();
    sreq_valid = 1'b0;
    drive_cores(); step();
    drive_cores(); step();
    chk("rst_mid_cureq", 128'(cureq_valid), 128'(4'hf));
    rst = 1'b1; cureq_ready = '0; cdrsp_valid = '0;
    step();
    chk("rst_mid_outputs", 128'({sreq_ready, cureq_valid, cdrsp_ready, srsp_valid, srsp_rsp,
                                 srsp_dirty, cureq_op, cureq_addr, srsp_data}), 128'(0));
    rst = 1'b0;
    step();
    chk("rst_mid_release", 128'({sreq_ready, srsp_valid}), 128'(2'b10));

`ifdef SNOOP_TIMEOUT_EN
    set_clean();
    p_dly[1] = 100000;
    run_txn(CUREQ_RD, 32'h8000, 1'b0, 2'd0, 0, 17, 1'b1, "timeout");
`endif

    // randomized transactions
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 4; i++) begin
        p_rsp[i]   = ($urandom_range(0, 7) == 0) ? CDRSP_ERROR : CDRSP_OKAY;
        p_dirty[i] = ($urandom_range(0, 2) == 0);
        p_data[i]  = {$urandom, $urandom};
        p_rdy[i]   = $urandom_range(0, 4);
        p_dly[i]   = $urandom_range(0, 4);
      end
      run_txn(2'($urandom_range(0, 2)), $urandom, 1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)), $urandom_range(0, 2), -1, 1'b0, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
